// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write bypass, load-use stall FSM and ID/EX register.
// Define ID_STALL_COUNTER_EN to build the saturating hazard-bubble counter on stall_count.
module id_stage_pipe #(
    parameter int DATA_W          = 32,
    parameter int REG_AW          = 5,
    parameter int CTRL_W          = 9,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic              flush,
    input  logic              freeze,
    input  logic              dbg_on,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              jump_take,
    output logic [31:0]       jump_addr,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_rega,
    output logic [DATA_W-1:0] out_regb,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [5:0]        out_opcode,
    output logic [15:0]       stall_count
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [1:0] CNT_INIT = (LOAD_USE_STALLS > 1) ? 2'(LOAD_USE_STALLS - 2) : 2'd0;

    state_t            state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] regs [2**REG_AW];

    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              wr_en;
    logic              hazard;
    logic              hazard_bubble;
    logic              bubble;
    logic [DATA_W-1:0] rega, regb, imm_ext;

    assign opcode = in_instr[31:26];
    assign imm    = in_instr[15:0];
    assign rs     = REG_AW'(in_instr[25:21]);
    assign rt     = REG_AW'(in_instr[20:16]);
    assign rd     = REG_AW'(in_instr[15:11]);

    assign wr_en = wb_we && !dbg_on && (wb_addr != '0);

    // Reads see a same-cycle write-back so the decode never picks up a stale value.
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] a);
        if (a == '0)
            return '0;
        else if (wr_en && (a == wb_addr))
            return wb_data;
        else
            return regs[a];
    endfunction

    assign rega     = read_port(rs);
    assign regb     = read_port(rt);
    assign dbg_data = read_port(dbg_addr);

    always_comb begin
        logic signed [15:0] simm;
        logic [DATA_W-1:0]  zimm;
        simm = imm;
        zimm = DATA_W'(imm);
        case (opcode)
            6'd12, 6'd13, 6'd14: imm_ext = zimm;
            6'd15:               imm_ext = zimm << 16;
            default:             imm_ext = DATA_W'(simm);
        endcase
    end

    assign hazard = in_valid && exe_mem_read && (exe_rd != '0) &&
                    ((exe_rd == rs) || (exe_rd == rt));

    // In STALL the exe_* inputs are ignored; the remaining bubbles come from cnt.
    assign hazard_bubble = !flush && ((state == STALL) || ((state == IDLE) && hazard));
    assign bubble        = flush || hazard_bubble;

    assign pc_write   = !freeze && !hazard_bubble;
    assign ifid_write = !freeze && !hazard_bubble;

    assign jump_take = in_valid && ((opcode == 6'd2) || (opcode == 6'd3)) &&
                       !hazard && (state == IDLE) && !freeze;
    assign jump_addr = {in_pc[31:28], in_instr[25:0], 2'b00};

    // Register file keeps writing during freeze; only debug mode blocks it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**REG_AW; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_pc     <= '0;
            out_rega   <= '0;
            out_regb   <= '0;
            out_imm    <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_rd     <= '0;
            out_opcode <= '0;
        end else if (!freeze) begin
            out_valid  <= bubble ? 1'b0 : in_valid;
            out_ctrl   <= bubble ? '0 : in_ctrl;
            out_pc     <= in_pc;
            out_rega   <= rega;
            out_regb   <= regb;
            out_imm    <= imm_ext;
            out_rs     <= rs;
            out_rt     <= rt;
            out_rd     <= rd;
            out_opcode <= opcode;

            if (flush) begin
                state <= IDLE;
                cnt   <= 2'd0;
            end else if (state == STALL) begin
                if (cnt == 2'd0)
                    state <= IDLE;
                else
                    cnt <= cnt - 2'd1;
            end else if (hazard) begin
                if (LOAD_USE_STALLS > 1) begin
                    state <= STALL;
                    cnt   <= CNT_INIT;
                end
            end
        end
    end

`ifdef ID_STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst)
            stall_count <= 16'd0;
        else if (!freeze && hazard_bubble && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe built with a two-bubble load-use stall.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [8:0]  in_ctrl;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exe_mem_read;
    logic [4:0]  exe_rd;
    logic        flush;
    logic        freeze;
    logic        dbg_on;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        pc_write;
    logic        ifid_write;
    logic        jump_take;
    logic [31:0] jump_addr;
    logic        out_valid;
    logic [8:0]  out_ctrl;
    logic [31:0] out_pc;
    logic [31:0] out_rega;
    logic [31:0] out_regb;
    logic [31:0] out_imm;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [5:0]  out_opcode;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    id_stage_pipe #(
        .DATA_W(32), .REG_AW(5), .CTRL_W(9), .LOAD_USE_STALLS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exe_mem_read(exe_mem_read), .exe_rd(exe_rd),
        .flush(flush), .freeze(freeze), .dbg_on(dbg_on),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .jump_take(jump_take), .jump_addr(jump_addr),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_rega(out_rega), .out_regb(out_regb), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_opcode(out_opcode), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

`ifdef ID_STALL_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [8:0] ctrl);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_ctrl  = ctrl;
    endtask

    // Outputs are sampled 1 ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm_f);
        return {op, rs_f, rt_f, imm_f};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f);
        return {6'd0, rs_f, rt_f, rd_f, 11'd0};
    endfunction

    logic [31:0] held_pc;
    logic [8:0]  held_ctrl;
    logic [5:0]  held_op;
    logic        held_valid;

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 9'd0);
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        exe_mem_read = 1'b0; exe_rd = '0;
        flush = 1'b0; freeze = 1'b0; dbg_on = 1'b0; dbg_addr = 5'd5;

        tick(); tick();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ctrl", 32'(out_ctrl), 32'd0);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_rega", out_rega, 32'd0);
        checkOutput("rst_imm", out_imm, 32'd0);
        checkOutput("rst_stall_count", 32'(stall_count), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst_reg5", dbg_data, 32'd0);

        // Write $5 while the decoded instruction reads it as rs.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        applyStimulus(1'b1, itype(6'd8, 5'd5, 5'd0, 16'h0001), 32'h100, 9'h1A5);
        #1;
        checkOutput("bypass_dbg", dbg_data, 32'h1234);
        tick();
        checkOutput("bypass_rega", out_rega, 32'h1234);
        checkOutput("load_valid", 32'(out_valid), 32'd1);
        checkOutput("load_ctrl", 32'(out_ctrl), 32'h1A5);
        checkOutput("load_pc", out_pc, 32'h100);
        checkOutput("load_rs", 32'(out_rs), 32'd5);
        checkOutput("load_opcode", 32'(out_opcode), 32'd8);
        checkOutput("load_imm", out_imm, 32'd1);

        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        dbg_addr = 5'd0;
        applyStimulus(1'b1, itype(6'd8, 5'd0, 5'd5, 16'h0000), 32'h104, 9'h001);
        #1;
        checkOutput("zero_dbg", dbg_data, 32'd0);
        tick();
        checkOutput("zero_rega", out_rega, 32'd0);
        checkOutput("stored_regb", out_regb, 32'h1234);

        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'hBEEF; dbg_on = 1'b1;
        tick();
        wb_we = 1'b0; dbg_on = 1'b0; dbg_addr = 5'd6;
        #1;
        checkOutput("dbg_blocks_write", dbg_data, 32'd0);

        applyStimulus(1'b1, itype(6'd8, 5'd0, 5'd1, 16'h8001), 32'h108, 9'h002);
        tick();
        checkOutput("imm_addi", out_imm, 32'hFFFF_8001);
        applyStimulus(1'b1, itype(6'd13, 5'd0, 5'd1, 16'h8001), 32'h10C, 9'h002);
        tick();
        checkOutput("imm_ori", out_imm, 32'h0000_8001);
        applyStimulus(1'b1, itype(6'd15, 5'd0, 5'd1, 16'h8001), 32'h110, 9'h002);
        tick();
        checkOutput("imm_lui", out_imm, 32'h8001_0000);

        // Load-use on rt=8: two bubbles, then normal flow.
        exe_mem_read = 1'b1; exe_rd = 5'd8;
        applyStimulus(1'b1, rtype(5'd1, 5'd8, 5'd3), 32'h114, 9'h0FF);
        #1;
        checkOutput("lu_pcw_c1", 32'(pc_write), 32'd0);
        checkOutput("lu_ifid_c1", 32'(ifid_write), 32'd0);
        tick();
        checkOutput("lu_valid_c1", 32'(out_valid), 32'd0);
        checkOutput("lu_ctrl_c1", 32'(out_ctrl), 32'd0);
        checkOutput("lu_rt_c1", 32'(out_rt), 32'd8);
        exe_mem_read = 1'b0;
        #1;
        checkOutput("lu_pcw_c2", 32'(pc_write), 32'd0);
        tick();
        checkOutput("lu_valid_c2", 32'(out_valid), 32'd0);
        checkOutput("lu_pcw_c3", 32'(pc_write), 32'd1);
        checkOutput("lu_stall_count", 32'(stall_count), CNT_EN ? 32'd2 : 32'd0);
        tick();
        checkOutput("lu_valid_c3", 32'(out_valid), 32'd1);
        checkOutput("lu_ctrl_c3", 32'(out_ctrl), 32'h0FF);

        // Hazard again, then flush in the second stall cycle.
        exe_mem_read = 1'b1; exe_rd = 5'd8;
        tick();
        checkOutput("fl_valid_c1", 32'(out_valid), 32'd0);
        exe_mem_read = 1'b0; flush = 1'b1;
        #1;
        checkOutput("fl_pcw_same", 32'(pc_write), 32'd1);
        tick();
        checkOutput("fl_valid_c2", 32'(out_valid), 32'd0);
        flush = 1'b0;
        #1;
        checkOutput("fl_pcw_idle", 32'(pc_write), 32'd1);
        tick();
        checkOutput("fl_valid_after", 32'(out_valid), 32'd1);
        checkOutput("fl_stall_count", 32'(stall_count), CNT_EN ? 32'd3 : 32'd0);

        applyStimulus(1'b1, {6'd2, 26'h0100000}, 32'h4000_0000, 9'h055);
        #1;
        checkOutput("j_take", 32'(jump_take), 32'd1);
        checkOutput("j_addr", jump_addr, 32'h4040_0000);
        tick();
        checkOutput("j_opcode", 32'(out_opcode), 32'd2);
        checkOutput("j_pc", out_pc, 32'h4000_0000);
        held_pc = 32'h4000_0000; held_ctrl = 9'h055; held_op = 6'd2; held_valid = 1'b1;

        freeze = 1'b1;
        applyStimulus(1'b1, {6'd3, 26'h0000010}, 32'h5000_0000, 9'h1F0);
        #1;
        checkOutput("frz_jump", 32'(jump_take), 32'd0);
        checkOutput("frz_pcw", 32'(pc_write), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_pc", out_pc, held_pc);
            checkOutput("frz_ctrl", 32'(out_ctrl), 32'(held_ctrl));
            checkOutput("frz_opcode", 32'(out_opcode), 32'(held_op));
            checkOutput("frz_valid", 32'(out_valid), 32'(held_valid));
        end
        freeze = 1'b0;
        tick();
        checkOutput("unfrz_opcode", 32'(out_opcode), 32'd3);
        checkOutput("unfrz_pc", out_pc, 32'h5000_0000);
        checkOutput("unfrz_ctrl", 32'(out_ctrl), 32'h1F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised successor of the MIPS decode stage. It combines the register file, the load-use hazard FSM and the ID/EX pipeline register in one block. Over the previous decode stage it adds:
- a configurable multi-cycle load-use stall;
- a write-to-read bypass;
- per-opcode immediate extension (sign, zero, LUI);
- jal support;
- a valid bit in the pipeline register;
- an optional stall counter.

It sits between the IF/ID register and the execute stage. Control bits come from the external control block through in_ctrl.

Parameters:
- DATA_W, 32, register and immediate width (must be >= 16).
- REG_AW, 5, register address width; the register file has 2**REG_AW entries.
- CTRL_W, 9, width of the control word carried to EX (WB/MEM/EXE fields are packed by the control block).
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  IF/ID slot holds a real instruction.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_ctrl  in  CTRL_W  decoded control word.
- wb_we  in  1  write-back enable.
- wb_addr  in  REG_AW  write-back register.
- wb_data  in  DATA_W  write-back data.
- exe_mem_read  in  1  instruction in EX is a load.
- exe_rd  in  REG_AW  destination of the instruction in EX.
- flush  in  1  branch flush; squashes the current ID slot.
- freeze  in  1  debug stop; holds all pipeline and FSM state.
- dbg_on  in  1  debug mode; blocks register-file writes.
- dbg_addr  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational register-file debug read.
- pc_write  out  1  PC update enable (0 during stall).
- ifid_write  out  1  IF/ID update enable (0 during stall).
- jump_take  out  1  combinational; j/jal decoded in a valid, non-stalled slot.
- jump_addr  out  32  {in_pc[31:28], in_instr[25:0], 2'b00}.
- out_valid  out  1  ID/EX slot valid.
- out_ctrl  out  CTRL_W  registered control word.
- out_pc  out  32  registered PC.
- out_rega, out_regb  out  DATA_W  registered operands.
- out_imm  out  DATA_W  registered extended immediate.
- out_rs, out_rt, out_rd  out  REG_AW  registered instr[25:21], [20:16], [15:11].
- out_opcode  out  6  registered instr[31:26].
- stall_count  out  16  bubble counter (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge):
  - all registered outputs go to 0 and out_valid goes to 0;
  - every register-file entry is cleared;
  - the FSM enters IDLE and the stall counter goes to 0.
- Register file:
  - write at posedge when wb_we && !dbg_on && wb_addr!=0;
  - entry 0 always reads 0;
  - reads are combinational, with bypass: a read address equal to a nonzero wb_addr, while wb_we && !dbg_on, returns wb_data in the same cycle.
- Hazard condition: in_valid && exe_mem_read && exe_rd!=0 && (exe_rd==rs || exe_rd==rt).
- FSM states are IDLE and STALL, with a 2-bit counter cnt.
  - IDLE, hazard present and no flush:
    - pc_write=0, ifid_write=0, bubble into ID/EX;
    - if LOAD_USE_STALLS>1, load cnt=LOAD_USE_STALLS-2 and go to STALL; otherwise stay in IDLE.
  - STALL:
    - pc_write=0, ifid_write=0, bubble each cycle;
    - if cnt==0, go to IDLE; otherwise decrement cnt;
    - exe_* inputs are ignored while in STALL.
  - Otherwise pc_write=ifid_write=1.
- Bubble: out_valid=0, out_ctrl=0. The other ID/EX fields still load the current decode values.
- Flush has priority over everything except reset and freeze:
  - ID/EX receives a bubble;
  - the FSM is forced to IDLE;
  - pc_write=ifid_write=1.
- Freeze:
  - ID/EX, FSM, cnt and stall counter hold their values;
  - pc_write=ifid_write=0;
  - the register file still writes unless dbg_on.
- Normal load (no hazard, no flush, no freeze):
  - ID/EX captures all decode values;
  - out_valid=in_valid, out_ctrl=in_ctrl.
  - Decode-to-EX latency is 1 cycle.
- Immediate extension, from opcode = instr[31:26] and imm = instr[15:0]:
  - opcode 12, 13, 14 (andi/ori/xori): zero-extend;
  - opcode 15 (lui): imm<<16, zero-filled to DATA_W;
  - all other opcodes: sign-extend.
- jump_take = in_valid && (opcode==2 || opcode==3) && !hazard && FSM==IDLE && !freeze.

Optional Feature:
- Macro: ID_STALL_COUNTER_EN.
- When defined: stall_count is a 16-bit register.
  - Increments by 1 on every non-frozen cycle that inserts a hazard bubble.
  - Flush bubbles are not counted.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: stall_count is tied to 0 and no counter logic is present.

Test Plan:
- Reset → with rst=0 for 2 cycles, all outputs read 0; after release, reading $5 returns 0.
- Write and bypass → wb_we=1, wb_addr=5, wb_data=0x1234 while in_instr reads rs=5: out_rega=0x1234 next cycle. A write to $0 leaves $0 reading 0.
- Load-use stall → exe_mem_read=1, exe_rd=8, rt=8, LOAD_USE_STALLS=2: pc_write/ifid_write are 0 for exactly 2 cycles, out_valid=0 for 2 cycles, and stall_count=2 with ID_STALL_COUNTER_EN defined.
- Flush during STALL → flush asserted in the 2nd stall cycle: FSM returns to IDLE, pc_write=1 the same cycle, out_valid=0.
- Immediate extension → imm=0x8001 with addi gives out_imm=0xFFFF8001; with ori gives 0x00008001; with lui gives 0x80010000.
- Jump and freeze:
  - j target 0x0100000 at in_pc=0x40000000 → jump_take=1, jump_addr=0x40400000;
  - freeze=1 for 3 cycles → all ID/EX outputs are unchanged and jump_take=0.
